// File: rtl/bus_arbiter_8.sv
// rtl/bus_arbiter_8.sv - eight-way round-robin bus arbiter with turnaround and hold limit
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-low reset
//   req[7:0]     level request per requester, bit i = requester i
//   grant[7:0]   one-hot grant decoded from the registered owner index, zero when no owner
//   grant_idx    index of the current or last owner
//   grant_valid  high while grant is non-zero
//   preempt      high during the dead cycle that follows a hold-limit release
//
// Parameter:
//   MAX_HOLD     consecutive grant cycles allowed while others wait (0..255, 0 disables)

module bus_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [7:0] grant,
   output logic [2:0] grant_idx,
   output logic       grant_valid,
   output logic       preempt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   localparam bit             HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [7:0]     HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

   state_t     state;
   state_t     state_n;
   logic [2:0] idx_n;
   logic [7:0] hold_cnt;
   logic [7:0] hold_n;
   logic       preempt_n;
   logic [2:0] winner;
   logic [7:0] owner_dec;
   logic       others_req;

   // Same equations as the 3-to-8 demux: one bit per owner index.
   assign owner_dec  = 8'b0000_0001 << grant_idx;
   assign others_req = |(req & ~owner_dec);

   // Round-robin search: scan idx+8 down to idx+1 so the nearest set bit
   // after the current owner is the last one assigned. The owner itself
   // (offset 8) therefore only wins when nobody else is asking.
   always_comb begin
      winner = grant_idx;
      for (int k = 8; k >= 1; k--) begin
         if (req[grant_idx + 3'(k)]) begin
            winner = grant_idx + 3'(k);
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         grant_idx <= 3'd7;
         hold_cnt  <= 8'd0;
         preempt   <= 1'b0;
      end else begin
         state     <= state_n;
         grant_idx <= idx_n;
         hold_cnt  <= hold_n;
         preempt   <= preempt_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n   = state;
      idx_n     = grant_idx;
      hold_n    = hold_cnt;
      preempt_n = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_n = GRANT;
               idx_n   = winner;
               hold_n  = 8'd0;
            end
         end
         GRANT: begin
            hold_n = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
            if (!req[grant_idx]) begin
               // Voluntary release wins over a coincident timeout.
               state_n = TURN;
            end else if (HOLD_EN && (hold_cnt >= HOLD_LAST) && others_req) begin
               // >= rather than == so an owner that ran uncontended past the
               // limit is released at the first cycle someone else asks.
               state_n   = TURN;
               preempt_n = 1'b1;
            end
         end
         TURN: begin
            if (|req) begin
               state_n = GRANT;
               idx_n   = winner;
               hold_n  = 8'd0;
            end else begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Output decode
   always_comb begin
      grant       = 8'h00;
      grant_valid = 1'b0;
      if (state == GRANT) begin
         grant       = owner_dec;
         grant_valid = 1'b1;
      end
   end

endmodule

// File: tb/tb_bus_arbiter_8.sv
// tb/tb_bus_arbiter_8.sv - directed bench for bus_arbiter_8

module tb_bus_arbiter_8;

   logic       clk;
   logic       rst_a, rst_b;
   logic [7:0] req_a, req_b;
   logic [7:0] grant_a, grant_b;
   logic [2:0] idx_a, idx_b;
   logic       gv_a, gv_b;
   logic       pre_a, pre_b;

   int tests;
   int fails;

   bus_arbiter_8 #(.MAX_HOLD(4)) u_dut (
      .clk         (clk),
      .rst         (rst_a),
      .req         (req_a),
      .grant       (grant_a),
      .grant_idx   (idx_a),
      .grant_valid (gv_a),
      .preempt     (pre_a)
   );

   bus_arbiter_8 #(.MAX_HOLD(0)) u_dut_nolimit (
      .clk         (clk),
      .rst         (rst_b),
      .req         (req_b),
      .grant       (grant_b),
      .grant_idx   (idx_b),
      .grant_valid (gv_b),
      .preempt     (pre_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      req_a = 8'h00;
      req_b = 8'h00;
      tick;
      rst_a = 1'b1;
      rst_b = 1'b1;

      // Reset state
      chk("rst_grant", grant_a, 8'h00);
      chk("rst_gv", {7'd0, gv_a}, 8'h00);
      chk("rst_idx", {5'd0, idx_a}, 8'h07);
      chk("rst_pre", {7'd0, pre_a}, 8'h00);

      // No requests: stays idle
      repeat (5) tick;
      chk("idle_grant", grant_a, 8'h00);
      chk("idle_gv", {7'd0, gv_a}, 8'h00);
      chk("idle_idx", {5'd0, idx_a}, 8'h07);

      // req=81: requester 0 first, then 7 after one dead cycle
      req_a = 8'h81;
      tick;
      chk("r81_first", grant_a, 8'h01);
      chk("r81_gv", {7'd0, gv_a}, 8'h01);
      tick;
      chk("r81_hold", grant_a, 8'h01);
      req_a = 8'h80;
      tick;
      chk("r81_turn", grant_a, 8'h00);
      chk("r81_turn_pre", {7'd0, pre_a}, 8'h00);
      tick;
      chk("r81_second", grant_a, 8'h80);
      chk("r81_idx", {5'd0, idx_a}, 8'h07);
      req_a = 8'h00;
      tick;
      chk("r81_rel", grant_a, 8'h00);
      tick;
      chk("r81_idle_gv", {7'd0, gv_a}, 8'h00);
      chk("r81_idle_idx", {5'd0, idx_a}, 8'h07);

      // req=FF, hold limit 4: 4 grant cycles then a preempt turn, wrapping 7->0
      req_a = 8'hFF;
      tick;
      for (int o = 0; o < 9; o++) begin
         for (int c = 0; c < 4; c++) begin
            chk("ff_grant", grant_a, 8'h01 << (o % 8));
            chk("ff_pre_low", {7'd0, pre_a}, 8'h00);
            tick;
         end
         chk("ff_turn", grant_a, 8'h00);
         chk("ff_turn_pre", {7'd0, pre_a}, 8'h01);
         tick;
      end
      chk("ff_after", grant_a, 8'h02);
      req_a = 8'h00;
      tick;
      chk("ff_rel_pre", {7'd0, pre_a}, 8'h00);
      tick;
      chk("ff_idle", grant_a, 8'h00);

      // No hold limit: requester 2 keeps the bus through hold_cnt saturation
      req_b = 8'h0C;
      tick;
      chk("nl_first", grant_b, 8'h04);
      for (int i = 0; i < 310; i++) begin
         tick;
         chk("nl_hold", grant_b, 8'h04);
         chk("nl_pre", {7'd0, pre_b}, 8'h00);
      end
      req_b = 8'h08;
      tick;
      chk("nl_turn", grant_b, 8'h00);
      chk("nl_turn_pre", {7'd0, pre_b}, 8'h00);
      tick;
      chk("nl_next", grant_b, 8'h08);
      req_b = 8'h00;

      // Owner 5 alone, then contended: released, re-granted when req[1] drops
      req_a = 8'h20;
      tick;
      for (int i = 0; i < 10; i++) begin
         chk("o5_alone", grant_a, 8'h20);
         chk("o5_alone_pre", {7'd0, pre_a}, 8'h00);
         tick;
      end
      req_a = 8'h22;
      tick;
      chk("o5_preempt", grant_a, 8'h00);
      chk("o5_preempt_pre", {7'd0, pre_a}, 8'h01);
      req_a = 8'h20;
      tick;
      chk("o5_regrant", grant_a, 8'h20);
      chk("o5_regrant_pre", {7'd0, pre_a}, 8'h00);
      req_a = 8'h00;
      tick;
      tick;

      // Reset while requester 6 owns the bus
      req_a = 8'h40;
      tick;
      chk("r6_grant", grant_a, 8'h40);
      rst_a = 1'b0;
      req_a = 8'h41;
      tick;
      chk("mid_rst_grant", grant_a, 8'h00);
      chk("mid_rst_gv", {7'd0, gv_a}, 8'h00);
      chk("mid_rst_idx", {5'd0, idx_a}, 8'h07);
      rst_a = 1'b1;
      tick;
      chk("post_rst_first", grant_a, 8'h01);

      // Release coinciding with timeout counts as voluntary
      tick;
      tick;
      tick;
      chk("coinc_hold4", grant_a, 8'h01);
      req_a = 8'h40;
      tick;
      chk("coinc_turn", grant_a, 8'h00);
      chk("coinc_pre", {7'd0, pre_a}, 8'h00);
      tick;
      chk("coinc_next", grant_a, 8'h40);
      req_a = 8'h00;
      tick;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
